// File: rtl/axi_lite_rd_arbiter.sv
// Two-master, one-slave AXI4-Lite read-channel arbiter with round-robin grant.
// One transaction in flight at a time; every output comes straight from a flop.
module axi_lite_rd_arbiter #(
  parameter int ADDRWIDTH = 32,
  parameter int DATAWIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [2*ADDRWIDTH-1:0] m_ARADDR,
  input  logic [5:0]             m_ARPROT,
  input  logic [1:0]             m_ARVALID,
  output logic [1:0]             m_ARREADY,
  output logic [2*DATAWIDTH-1:0] m_RDATA,
  output logic [3:0]             m_RRESP,
  output logic [1:0]             m_RVALID,
  input  logic [1:0]             m_RREADY,
  output logic [ADDRWIDTH-1:0]   s_ARADDR,
  output logic [2:0]             s_ARPROT,
  output logic                   s_ARVALID,
  input  logic                   s_ARREADY,
  input  logic [DATAWIDTH-1:0]   s_RDATA,
  input  logic [1:0]             s_RRESP,
  input  logic                   s_RVALID,
  output logic                   s_RREADY,
  output logic                   busy,
  output logic [1:0]             grant
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_GRANT = 3'd1,
    S_SADDR = 3'd2,
    S_SDATA = 3'd3,
    S_MRESP = 3'd4
  } state_t;

  state_t                 r_state;
  logic                   r_last_grant;
  logic [1:0]             r_grant;
  logic                   r_busy;
  logic [1:0]             r_m_arready;
  logic [ADDRWIDTH-1:0]   r_s_araddr;
  logic [2:0]             r_s_arprot;
  logic                   r_s_arvalid;
  logic                   r_s_rready;
  logic [2*DATAWIDTH-1:0] r_m_rdata;
  logic [3:0]             r_m_rresp;
  logic [1:0]             r_m_rvalid;

  state_t                 w_nxt_state;
  logic                   w_nxt_last_grant;
  logic [1:0]             w_nxt_grant;
  logic                   w_nxt_busy;
  logic [1:0]             w_nxt_m_arready;
  logic [ADDRWIDTH-1:0]   w_nxt_s_araddr;
  logic [2:0]             w_nxt_s_arprot;
  logic                   w_nxt_s_arvalid;
  logic                   w_nxt_s_rready;
  logic [2*DATAWIDTH-1:0] w_nxt_m_rdata;
  logic [3:0]             w_nxt_m_rresp;
  logic [1:0]             w_nxt_m_rvalid;

  logic                   w_gidx;
  logic                   w_pick;

  // Index of the current owner, and the winner if arbitration happened now.
  assign w_gidx = r_grant[1];
  assign w_pick = (&m_ARVALID) ? ~r_last_grant : m_ARVALID[1];

  always_comb begin
    // NOTE: every next value defaults to its current value before the case, so no path infers a latch.
    w_nxt_state      = r_state;
    w_nxt_last_grant = r_last_grant;
    w_nxt_grant      = r_grant;
    w_nxt_busy       = r_busy;
    w_nxt_m_arready  = r_m_arready;
    w_nxt_s_araddr   = r_s_araddr;
    w_nxt_s_arprot   = r_s_arprot;
    w_nxt_s_arvalid  = r_s_arvalid;
    w_nxt_s_rready   = r_s_rready;
    w_nxt_m_rdata    = r_m_rdata;
    w_nxt_m_rresp    = r_m_rresp;
    w_nxt_m_rvalid   = r_m_rvalid;

    case (r_state)
      S_IDLE: begin
        if (|m_ARVALID) begin
          w_nxt_grant     = w_pick ? 2'b10 : 2'b01;
          w_nxt_busy      = 1'b1;
          w_nxt_m_arready = w_pick ? 2'b10 : 2'b01;
          w_nxt_state     = S_GRANT;
        end
      end

      S_GRANT: begin
        if (m_ARVALID[w_gidx] && r_m_arready[w_gidx]) begin
          w_nxt_s_araddr  = w_gidx ? m_ARADDR[2*ADDRWIDTH-1:ADDRWIDTH] : m_ARADDR[ADDRWIDTH-1:0];
          w_nxt_s_arprot  = w_gidx ? m_ARPROT[5:3] : m_ARPROT[2:0];
          w_nxt_m_arready = 2'b00;
          w_nxt_s_arvalid = 1'b1;
          w_nxt_state     = S_SADDR;
        end
      end

      S_SADDR: begin
        if (r_s_arvalid && s_ARREADY) begin
          w_nxt_s_arvalid = 1'b0;
          w_nxt_s_rready  = 1'b1;
          w_nxt_state     = S_SDATA;
        end
      end

      S_SDATA: begin
        if (s_RVALID && r_s_rready) begin
          w_nxt_s_rready = 1'b0;
          // Only the owner's slice is updated; the other master keeps its last read.
          if (w_gidx) begin
            w_nxt_m_rdata[2*DATAWIDTH-1:DATAWIDTH] = s_RDATA;
            w_nxt_m_rresp[3:2]                     = s_RRESP;
          end else begin
            w_nxt_m_rdata[DATAWIDTH-1:0] = s_RDATA;
            w_nxt_m_rresp[1:0]           = s_RRESP;
          end
          w_nxt_m_rvalid = r_grant;
          w_nxt_state    = S_MRESP;
        end
      end

      S_MRESP: begin
        if (|(r_m_rvalid & m_RREADY)) begin
          w_nxt_m_rvalid   = 2'b00;
          w_nxt_last_grant = w_gidx;
          w_nxt_grant      = 2'b00;
          w_nxt_busy       = 1'b0;
          w_nxt_state      = S_IDLE;
        end
      end

      default: begin
        w_nxt_state     = S_IDLE;
        w_nxt_grant     = 2'b00;
        w_nxt_busy      = 1'b0;
        w_nxt_m_arready = 2'b00;
        w_nxt_s_araddr  = '0;
        w_nxt_s_arprot  = 3'b000;
        w_nxt_s_arvalid = 1'b0;
        w_nxt_s_rready  = 1'b0;
        w_nxt_m_rdata   = '0;
        w_nxt_m_rresp   = 4'b0000;
        w_nxt_m_rvalid  = 2'b00;
      end
    endcase
  end

  // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_last_grant <= 1'b1;
      r_grant      <= 2'b00;
      r_busy       <= 1'b0;
      r_m_arready  <= 2'b00;
      r_s_araddr   <= '0;
      r_s_arprot   <= 3'b000;
      r_s_arvalid  <= 1'b0;
      r_s_rready   <= 1'b0;
      r_m_rdata    <= '0;
      r_m_rresp    <= 4'b0000;
      r_m_rvalid   <= 2'b00;
    end else begin
      r_state      <= w_nxt_state;
      r_last_grant <= w_nxt_last_grant;
      r_grant      <= w_nxt_grant;
      r_busy       <= w_nxt_busy;
      r_m_arready  <= w_nxt_m_arready;
      r_s_araddr   <= w_nxt_s_araddr;
      r_s_arprot   <= w_nxt_s_arprot;
      r_s_arvalid  <= w_nxt_s_arvalid;
      r_s_rready   <= w_nxt_s_rready;
      r_m_rdata    <= w_nxt_m_rdata;
      r_m_rresp    <= w_nxt_m_rresp;
      r_m_rvalid   <= w_nxt_m_rvalid;
    end
  end

  assign m_ARREADY = r_m_arready;
  assign m_RDATA   = r_m_rdata;
  assign m_RRESP   = r_m_rresp;
  assign m_RVALID  = r_m_rvalid;
  assign s_ARADDR  = r_s_araddr;
  assign s_ARPROT  = r_s_arprot;
  assign s_ARVALID = r_s_arvalid;
  assign s_RREADY  = r_s_rready;
  assign busy      = r_busy;
  assign grant     = r_grant;

endmodule

// File: tb/tb_axi_lite_rd_arbiter.sv
// Directed bench for axi_lite_rd_arbiter: the bench plays both masters and the slave.
module tb_axi_lite_rd_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] m_ARADDR = '0;
  logic [5:0]  m_ARPROT = '0;
  logic [1:0]  m_ARVALID = '0;
  logic [1:0]  m_ARREADY;
  logic [63:0] m_RDATA;
  logic [3:0]  m_RRESP;
  logic [1:0]  m_RVALID;
  logic [1:0]  m_RREADY = '0;
  logic [31:0] s_ARADDR;
  logic [2:0]  s_ARPROT;
  logic        s_ARVALID;
  logic        s_ARREADY = 1'b0;
  logic [31:0] s_RDATA = '0;
  logic [1:0]  s_RRESP = '0;
  logic        s_RVALID = 1'b0;
  logic        s_RREADY;
  logic        busy;
  logic [1:0]  grant;

  int n_tests = 0;
  int n_fail  = 0;

  axi_lite_rd_arbiter #(.ADDRWIDTH(32), .DATAWIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .m_ARADDR(m_ARADDR), .m_ARPROT(m_ARPROT), .m_ARVALID(m_ARVALID), .m_ARREADY(m_ARREADY),
    .m_RDATA(m_RDATA), .m_RRESP(m_RRESP), .m_RVALID(m_RVALID), .m_RREADY(m_RREADY),
    .s_ARADDR(s_ARADDR), .s_ARPROT(s_ARPROT), .s_ARVALID(s_ARVALID), .s_ARREADY(s_ARREADY),
    .s_RDATA(s_RDATA), .s_RRESP(s_RRESP), .s_RVALID(s_RVALID), .s_RREADY(s_RREADY),
    .busy(busy), .grant(grant)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    m_ARVALID = '0; m_RREADY = '0; s_ARREADY = 1'b0; s_RVALID = 1'b0;
    step(); step();
    rst = 1'b0;
    step();
  endtask

  task automatic raise(input int m, input logic [31:0] addr, input logic [2:0] prot);
    m_ARADDR[m*32 +: 32] = addr;
    m_ARPROT[m*3 +: 3]   = prot;
    m_ARVALID[m]         = 1'b1;
  endtask

  // Drives one complete read for master m, assuming its ARVALID is already up.
  task automatic serve(input int m, input logic [31:0] addr, input logic [2:0] prot,
                       input logic [31:0] sdata, input logic [1:0] sresp,
                       input int ar_stall, input int r_stall, input bit late);
    int n;
    int o;
    logic [1:0] oh;
    o  = 1 - m;
    oh = (m == 1) ? 2'b10 : 2'b01;
    n  = 0;
    while (m_ARREADY[m] !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    check("m_arready_up", {63'd0, m_ARREADY[m]}, 64'd1);
    check("grant_onehot", {62'd0, grant}, {62'd0, oh});
    check("busy_set", {63'd0, busy}, 64'd1);
    check("other_arready_low", {63'd0, m_ARREADY[o]}, 64'd0);
    step();
    m_ARVALID[m] = 1'b0;
    check("s_arvalid_up", {63'd0, s_ARVALID}, 64'd1);
    check("s_araddr", {32'd0, s_ARADDR}, {32'd0, addr});
    check("s_arprot", {61'd0, s_ARPROT}, {61'd0, prot});
    check("m_arready_drop", {63'd0, m_ARREADY[m]}, 64'd0);
    for (int i = 0; i < ar_stall; i++) begin
      step();
      check("s_arvalid_hold", {63'd0, s_ARVALID}, 64'd1);
      check("s_araddr_hold", {32'd0, s_ARADDR}, {32'd0, addr});
    end
    s_ARREADY = 1'b1;
    step();
    s_ARREADY = 1'b0;
    check("s_arvalid_clr", {63'd0, s_ARVALID}, 64'd0);
    check("s_rready_up", {63'd0, s_RREADY}, 64'd1);
    if (late) m_ARVALID[o] = 1'b1;
    s_RVALID = 1'b1; s_RDATA = sdata; s_RRESP = sresp;
    step();
    s_RVALID = 1'b0; s_RDATA = 32'hDEAD_BEEF; s_RRESP = 2'b11;
    check("m_rvalid", {62'd0, m_RVALID}, {62'd0, oh});
    check("m_rdata", {32'd0, m_RDATA[m*32 +: 32]}, {32'd0, sdata});
    check("m_rresp", {62'd0, m_RRESP[m*2 +: 2]}, {62'd0, sresp});
    check("s_rready_clr", {63'd0, s_RREADY}, 64'd0);
    check("no_dup_s_arvalid", {63'd0, s_ARVALID}, 64'd0);
    if (late) check("late_arready_low", {63'd0, m_ARREADY[o]}, 64'd0);
    for (int i = 0; i < r_stall; i++) begin
      step();
      check("m_rvalid_hold", {62'd0, m_RVALID}, {62'd0, oh});
      check("m_rdata_hold", {32'd0, m_RDATA[m*32 +: 32]}, {32'd0, sdata});
    end
    m_RREADY[m] = 1'b1;
    step();
    m_RREADY[m] = 1'b0;
    check("m_rvalid_clr", {62'd0, m_RVALID}, 64'd0);
    check("busy_clr", {63'd0, busy}, 64'd0);
    check("grant_clr", {62'd0, grant}, 64'd0);
    check("m_rdata_keep", {32'd0, m_RDATA[m*32 +: 32]}, {32'd0, sdata});
  endtask

  initial begin
    do_reset();

    // Reset state
    check("rst_grant", {62'd0, grant}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_m_rdata", m_RDATA, 64'd0);
    check("rst_s_arvalid", {63'd0, s_ARVALID}, 64'd0);

    // Single request from m0
    raise(0, 32'h4, 3'b001);
    serve(0, 32'h4, 3'b001, 32'h1122_3344, 2'b00, 0, 0, 1'b0);
    check("single_m1_slice_zero", {32'd0, m_RDATA[63:32]}, 64'd0);
    check("single_m1_rresp_zero", {62'd0, m_RRESP[3:2]}, 64'd0);

    // Contention after reset: m0, m1, m0, m1
    do_reset();
    raise(0, 32'h8, 3'b010);
    raise(1, 32'hC, 3'b101);
    serve(0, 32'h8, 3'b010, 32'hA0A0_0008, 2'b00, 0, 0, 1'b0);
    serve(1, 32'hC, 3'b101, 32'hB1B1_000C, 2'b01, 0, 0, 1'b0);
    check("m0_slice_kept", {32'd0, m_RDATA[31:0]}, 64'h0000_0000_A0A0_0008);
    raise(0, 32'h18, 3'b000);
    raise(1, 32'h1C, 3'b011);
    serve(0, 32'h18, 3'b000, 32'hC2C2_0018, 2'b00, 0, 0, 1'b0);
    serve(1, 32'h1C, 3'b011, 32'hD3D3_001C, 2'b00, 0, 0, 1'b0);

    // Back-pressure on the slave AR and the master R channel
    raise(1, 32'h20, 3'b110);
    serve(1, 32'h20, 3'b110, 32'h5566_7788, 2'b00, 5, 4, 1'b0);

    // SLVERR passthrough
    raise(1, 32'h10, 3'b000);
    serve(1, 32'h10, 3'b000, 32'hCAFE_F00D, 2'b10, 0, 0, 1'b0);
    check("err_rresp", {60'd0, m_RRESP}, {60'd0, 2'b10, 2'b00});
    check("err_rdata", m_RDATA, {32'hCAFE_F00D, 32'hC2C2_0018});

    // Late arrival: m1 raises ARVALID while m0 sits in SDATA
    m_ARADDR[63:32] = 32'h44;
    m_ARPROT[5:3]   = 3'b100;
    raise(0, 32'h40, 3'b000);
    serve(0, 32'h40, 3'b000, 32'h0BAD_CAFE, 2'b00, 0, 2, 1'b1);
    check("late_idle_arready", {62'd0, m_ARREADY}, 64'd0);
    step();
    check("late_granted_next", {62'd0, m_ARREADY}, 64'd2);
    serve(1, 32'h44, 3'b100, 32'h4444_4444, 2'b00, 0, 0, 1'b0);

    // Reset in SADDR clears all outputs at once
    raise(0, 32'h80, 3'b111);
    begin
      int n;
      n = 0;
      while (s_ARVALID !== 1'b1 && n < 20) begin
        step();
        n++;
      end
    end
    check("pre_rst_s_arvalid", {63'd0, s_ARVALID}, 64'd1);
    m_ARVALID = '0;
    #1 rst = 1'b1;
    #1;
    check("mid_rst_s_arvalid", {63'd0, s_ARVALID}, 64'd0);
    check("mid_rst_s_araddr", {32'd0, s_ARADDR}, 64'd0);
    check("mid_rst_grant", {62'd0, grant}, 64'd0);
    check("mid_rst_busy", {63'd0, busy}, 64'd0);
    check("mid_rst_m_rdata", m_RDATA, 64'd0);
    check("mid_rst_ready_valid", {56'd0, m_ARREADY, m_RVALID, s_RREADY, 3'd0}, 64'd0);
    step();
    rst = 1'b0;
    step();
    raise(1, 32'h90, 3'b010);
    serve(1, 32'h90, 3'b010, 32'h9090_9090, 2'b00, 0, 0, 1'b0);
    raise(0, 32'hA0, 3'b000);
    raise(1, 32'hA4, 3'b000);
    serve(0, 32'hA0, 3'b000, 32'hA0A0_A0A0, 2'b00, 0, 0, 1'b0);
    serve(1, 32'hA4, 3'b000, 32'hA4A4_A4A4, 2'b00, 0, 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
